// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and cache-stall control for the 5-stage RV32I pipeline.
// Produces the packed control word plus split I/D response hold flags and perf counters.
package control_itf;
  typedef struct packed {
    logic [1:0] rs1mux_sel;
    logic [1:0] rs2mux_sel;
    logic       pipe_load_ifid;
    logic       pipe_load_idex;
    logic       pipe_load_exmem;
    logic       pipe_load_memwb;
    logic       pipe_rst_ifid;
    logic       pipe_rst_idex;
    logic       pipe_rst_exmem;
    logic       pipe_rst_memwb;
  } control;
endpackage

// Per-source forwarding select; EX/MEM result wins over MEM/WB.
module hazard_fwd (
  input  logic [4:0] rs,
  input  logic [4:0] exmem_rd,
  input  logic [4:0] memwb_rd,
  input  logic       exmem_load_regfile,
  input  logic       memwb_load_regfile,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (memwb_load_regfile && memwb_rd != 5'd0 && memwb_rd == rs) sel = 2'b10;
    if (exmem_load_regfile && exmem_rd != 5'd0 && exmem_rd == rs) sel = 2'b01;
  end
endmodule

module hazard_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           ifid_rs1,
  input  logic [4:0]           ifid_rs2,
  input  logic [4:0]           idex_rs1,
  input  logic [4:0]           idex_rs2,
  input  logic [4:0]           idex_rd,
  input  logic                 idex_dcache_read,
  input  logic                 br_taken,
  input  logic [4:0]           exmem_rd,
  input  logic [4:0]           memwb_rd,
  input  logic                 exmem_load_regfile,
  input  logic                 memwb_load_regfile,
  input  logic                 icache_read,
  input  logic                 icache_resp,
  input  logic                 dcache_req,
  input  logic                 dcache_resp,
  input  logic                 cnt_clr,
  output control_itf::control  ctrl,
  output logic                 i_hold,
  output logic                 d_hold,
  output logic [CNT_WIDTH-1:0] cnt_mem_stall,
  output logic [CNT_WIDTH-1:0] cnt_bubble,
  output logic [CNT_WIDTH-1:0] cnt_flush
);
  localparam int NUM_SRC = 2;

  typedef enum logic {RUN, WAIT} state_t;
  state_t state;

  logic [NUM_SRC-1:0][4:0] src_rs;
  logic [NUM_SRC-1:0][1:0] fwd_sel;

  assign src_rs = {idex_rs2, idex_rs1};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    hazard_fwd u_fwd (
      .rs                 (src_rs[g]),
      .exmem_rd           (exmem_rd),
      .memwb_rd           (memwb_rd),
      .exmem_load_regfile (exmem_load_regfile),
      .memwb_load_regfile (memwb_load_regfile),
      .sel                (fwd_sel[g])
    );
  end

  logic i_pend, d_pend, mem_stall, load_use, flush_cyc, bubble_cyc;

  assign i_pend     = icache_read & ~icache_resp & ~i_hold;
  assign d_pend     = dcache_req  & ~dcache_resp & ~d_hold;
  assign mem_stall  = i_pend | d_pend;
  assign load_use   = idex_dcache_read && idex_rd != 5'd0 &&
                      (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  assign flush_cyc  = ~mem_stall & br_taken;
  assign bubble_cyc = ~mem_stall & ~br_taken & load_use;

  // The advance out of a stall is combinational so the cycle the last response lands is used.
  always_comb begin
    ctrl = '0;
    ctrl.rs1mux_sel = fwd_sel[0];
    ctrl.rs2mux_sel = fwd_sel[1];
    if (!rst) begin
      ctrl = '0;
      {ctrl.pipe_rst_ifid, ctrl.pipe_rst_idex, ctrl.pipe_rst_exmem, ctrl.pipe_rst_memwb} = 4'hF;
    end else if (!mem_stall) begin
      {ctrl.pipe_load_ifid, ctrl.pipe_load_idex, ctrl.pipe_load_exmem, ctrl.pipe_load_memwb} = 4'hF;
      if (br_taken) begin
        ctrl.pipe_rst_ifid = 1'b1;
        ctrl.pipe_rst_idex = 1'b1;
      end else if (load_use) begin
        ctrl.pipe_load_ifid = 1'b0;
        ctrl.pipe_rst_idex  = 1'b1;
      end
    end
  end

  // A response that lands while the other side is still outstanding is latched so it is not lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      i_hold <= 1'b0;
      d_hold <= 1'b0;
    end else begin
      case (state)
        RUN: if (mem_stall) begin
          state  <= WAIT;
          i_hold <= icache_resp & d_pend;
          d_hold <= dcache_resp & i_pend;
        end
        WAIT: if (!mem_stall) begin
          state  <= RUN;
          i_hold <= 1'b0;
          d_hold <= 1'b0;
        end else begin
          i_hold <= i_hold | (icache_resp & d_pend);
          d_hold <= d_hold | (dcache_resp & i_pend);
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_mem_stall <= '0;
      cnt_bubble    <= '0;
      cnt_flush     <= '0;
    end else if (cnt_clr) begin
      cnt_mem_stall <= '0;
      cnt_bubble    <= '0;
      cnt_flush     <= '0;
    end else begin
      if (mem_stall)  cnt_mem_stall <= cnt_mem_stall + CNT_WIDTH'(1);
      if (bubble_cyc) cnt_bubble    <= cnt_bubble    + CNT_WIDTH'(1);
      if (flush_cyc)  cnt_flush     <= cnt_flush     + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, flush, split cache stalls, reset, counter wrap.
module tb_hazard_ctrl;
  localparam int CW = 4;
  // {rs1sel, rs2sel, load ifid/idex/exmem/memwb, rst ifid/idex/exmem/memwb}
  localparam logic [11:0] C_RESET  = 12'h00F;
  localparam logic [11:0] C_NORMAL = 12'h0F0;
  localparam logic [11:0] C_STALL  = 12'h000;
  localparam logic [11:0] C_FLUSH  = 12'h0FC;
  localparam logic [11:0] C_LDUSE  = 12'h074;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic idex_dcache_read, br_taken, exmem_load_regfile, memwb_load_regfile;
  logic icache_read, icache_resp, dcache_req, dcache_resp, cnt_clr;
  logic [11:0] ctrl;
  logic i_hold, d_hold;
  logic [CW-1:0] cnt_mem_stall, cnt_bubble, cnt_flush;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_dcache_read(idex_dcache_read), .br_taken(br_taken),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_load_regfile(exmem_load_regfile), .memwb_load_regfile(memwb_load_regfile),
    .icache_read(icache_read), .icache_resp(icache_resp),
    .dcache_req(dcache_req), .dcache_resp(dcache_resp),
    .cnt_clr(cnt_clr), .ctrl(ctrl), .i_hold(i_hold), .d_hold(d_hold),
    .cnt_mem_stall(cnt_mem_stall), .cnt_bubble(cnt_bubble), .cnt_flush(cnt_flush)
  );

  task automatic idle();
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
    exmem_rd = 0; memwb_rd = 0; idex_dcache_read = 0; br_taken = 0;
    exmem_load_regfile = 0; memwb_load_regfile = 0;
    icache_read = 0; icache_resp = 0; dcache_req = 0; dcache_resp = 0; cnt_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_cnt();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle();
    @(negedge clk);
    checks++; if (ctrl !== C_RESET) begin errors++; $display("FAIL reset_ctrl: got %h exp %h", ctrl, C_RESET); end
    checks++; if ({i_hold, d_hold} !== 2'b00) begin errors++; $display("FAIL reset_hold: got %b exp 00", {i_hold, d_hold}); end
    checks++; if ({cnt_mem_stall, cnt_bubble, cnt_flush} !== '0) begin errors++; $display("FAIL reset_cnt: got %h exp 0", {cnt_mem_stall, cnt_bubble, cnt_flush}); end
    tick(); rst = 1'b1;
    @(negedge clk);
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL reset_release: got %h exp %h", ctrl, C_NORMAL); end
  endtask

  task automatic test_forwarding();
    tick();
    exmem_rd = 5; memwb_rd = 5; exmem_load_regfile = 1; memwb_load_regfile = 1; idex_rs1 = 5; idex_rs2 = 0;
    @(negedge clk);
    checks++; if (ctrl !== 12'h4F0) begin errors++; $display("FAIL fwd_exmem_prio: got %h exp 4f0", ctrl); end
    tick(); memwb_rd = 0; idex_rs2 = 0;
    @(negedge clk);
    checks++; if (ctrl !== 12'h4F0) begin errors++; $display("FAIL fwd_x0: got %h exp 4f0", ctrl); end
    tick(); exmem_load_regfile = 0; memwb_rd = 5; idex_rs2 = 5;
    @(negedge clk);
    checks++; if (ctrl !== 12'hAF0) begin errors++; $display("FAIL fwd_memwb: got %h exp af0", ctrl); end
    tick(); exmem_load_regfile = 1; exmem_rd = 7; memwb_load_regfile = 0; idex_rs1 = 7; idex_rs2 = 5;
    @(negedge clk);
    checks++; if (ctrl !== 12'h4F0) begin errors++; $display("FAIL fwd_memwb_noload: got %h exp 4f0", ctrl); end
    idle();
  endtask

  task automatic test_load_use();
    tick(); clr_cnt();
    idex_dcache_read = 1; idex_rd = 3; ifid_rs2 = 3;
    @(negedge clk);
    checks++; if (ctrl !== C_LDUSE) begin errors++; $display("FAIL lduse_ctrl: got %h exp %h", ctrl, C_LDUSE); end
    tick(); idle();
    idex_dcache_read = 1; idex_rd = 0; ifid_rs1 = 0;
    @(negedge clk);
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL lduse_x0: got %h exp %h", ctrl, C_NORMAL); end
    tick(); idle();
    @(negedge clk);
    checks++; if (cnt_bubble !== 4'd1) begin errors++; $display("FAIL lduse_cnt: got %0d exp 1", cnt_bubble); end
  endtask

  task automatic test_flush_priority();
    tick(); clr_cnt();
    br_taken = 1; idex_dcache_read = 1; idex_rd = 3; ifid_rs2 = 3;
    @(negedge clk);
    checks++; if (ctrl !== C_FLUSH) begin errors++; $display("FAIL flush_ctrl: got %h exp %h", ctrl, C_FLUSH); end
    tick(); idle();
    @(negedge clk);
    checks++; if (cnt_flush !== 4'd1) begin errors++; $display("FAIL flush_cnt: got %0d exp 1", cnt_flush); end
    checks++; if (cnt_bubble !== 4'd0) begin errors++; $display("FAIL flush_bubble: got %0d exp 0", cnt_bubble); end
  endtask

  task automatic test_stall_masks_flush();
    tick(); clr_cnt();
    icache_read = 1; br_taken = 1;
    @(negedge clk);
    checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL stallflush_hold: got %h exp %h", ctrl, C_STALL); end
    tick(); icache_resp = 1;
    @(negedge clk);
    checks++; if (ctrl !== C_FLUSH) begin errors++; $display("FAIL stallflush_release: got %h exp %h", ctrl, C_FLUSH); end
    tick(); idle();
    @(negedge clk);
    checks++; if (cnt_flush !== 4'd1) begin errors++; $display("FAIL stallflush_fcnt: got %0d exp 1", cnt_flush); end
    checks++; if (cnt_mem_stall !== 4'd1) begin errors++; $display("FAIL stallflush_scnt: got %0d exp 1", cnt_mem_stall); end
  endtask

  task automatic test_split_resp();
    logic [11:0] exp_ctrl;
    logic exp_ih;
    tick(); clr_cnt();
    for (int c = 0; c < 8; c++) begin
      icache_read = (c < 7); dcache_req = (c < 7);
      icache_resp = (c == 2); dcache_resp = (c == 6);
      exp_ctrl = (c <= 5) ? C_STALL : C_NORMAL;
      exp_ih   = (c >= 3 && c <= 6);
      @(negedge clk);
      checks++; if (ctrl !== exp_ctrl) begin errors++; $display("FAIL split_ctrl c%0d: got %h exp %h", c, ctrl, exp_ctrl); end
      checks++; if (i_hold !== exp_ih || d_hold !== 1'b0) begin errors++; $display("FAIL split_hold c%0d: got i%b d%b exp i%b d0", c, i_hold, d_hold, exp_ih); end
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if (cnt_mem_stall !== 4'd6) begin errors++; $display("FAIL split_cnt: got %0d exp 6", cnt_mem_stall); end
  endtask

  task automatic test_reset_mid_stall();
    tick();
    icache_read = 1; dcache_req = 1;
    tick(); dcache_resp = 1;
    tick(); dcache_resp = 0;
    @(negedge clk);
    checks++; if (d_hold !== 1'b1) begin errors++; $display("FAIL midrst_dhold_set: got %b exp 1", d_hold); end
    checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL midrst_stall: got %h exp %h", ctrl, C_STALL); end
    #1 rst = 1'b0;
    #1;
    checks++; if (ctrl !== C_RESET) begin errors++; $display("FAIL midrst_ctrl: got %h exp %h", ctrl, C_RESET); end
    checks++; if (d_hold !== 1'b0) begin errors++; $display("FAIL midrst_dhold: got %b exp 0", d_hold); end
    checks++; if (cnt_mem_stall !== 4'd0) begin errors++; $display("FAIL midrst_cnt: got %0d exp 0", cnt_mem_stall); end
    idle(); tick(); tick(); rst = 1'b1;
    @(negedge clk);
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL midrst_release: got %h exp %h", ctrl, C_NORMAL); end
    tick(); icache_read = 1; icache_resp = 1;
    @(negedge clk);
    checks++; if (ctrl !== C_NORMAL) begin errors++; $display("FAIL midrst_run: got %h exp %h", ctrl, C_NORMAL); end
    tick(); idle();
    @(negedge clk);
    checks++; if (cnt_mem_stall !== 4'd0 || i_hold !== 1'b0) begin errors++; $display("FAIL midrst_after: got cnt %0d ih %b exp 0 0", cnt_mem_stall, i_hold); end
  endtask

  task automatic test_counter_wrap();
    tick(); clr_cnt();
    br_taken = 1;
    repeat (17) tick();
    br_taken = 0;
    @(negedge clk);
    checks++; if (cnt_flush !== 4'd1) begin errors++; $display("FAIL wrap_cnt: got %0d exp 1", cnt_flush); end
    tick(); br_taken = 1; cnt_clr = 1;
    tick(); br_taken = 0; cnt_clr = 0;
    @(negedge clk);
    checks++; if (cnt_flush !== 4'd0) begin errors++; $display("FAIL wrap_clr_prio: got %0d exp 0", cnt_flush); end
    tick(); br_taken = 1;
    tick(); br_taken = 0;
    @(negedge clk);
    checks++; if (cnt_flush !== 4'd1) begin errors++; $display("FAIL wrap_after_clr: got %0d exp 1", cnt_flush); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_flush_priority();
    test_stall_masks_flush();
    test_split_resp();
    test_reset_mid_stall();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
